// File: rtl/store_buf_pkg.sv
// Shared MIPS MEM-stage definitions: opcode constants, store lane encoding,
// and the write-buffer entry layout used by store_buf and st_fifo.
package store_buf_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic {
    DR_IDLE = 1'b0,
    DR_REQ  = 1'b1
  } drain_state_e;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } lane_t;

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  be;
    logic [31:0] data;
  } st_entry_t;

  function automatic logic is_store_op(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_load_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  // Byte enables and lane-replicated data; non-stores encode as no-write.
  function automatic lane_t lane_encode(input logic [5:0]  op,
                                        input logic [1:0]  lo,
                                        input logic [31:0] wdata);
    lane_t l;
    case (op)
      OP_SW: begin
        l.be   = 4'b1111;
        l.data = wdata;
      end
      OP_SH: begin
        l.be   = lo[1] ? 4'b1100 : 4'b0011;
        l.data = {2{wdata[15:0]}};
      end
      OP_SB: begin
        l.be   = 4'b0001 << lo;
        l.data = {4{wdata[7:0]}};
      end
      default: begin
        l.be   = 4'b0000;
        l.data = 32'h0000_0000;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/store_buf_st_fifo.sv
// DEPTH-entry store FIFO with occupancy count, per-entry valid bits and a
// word-address match port used for load-after-store hazard detection.
module st_fifo
  import store_buf_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = PW + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  st_entry_t   push_entry_i,
  input  logic        pop_i,
  input  logic [29:0] match_waddr_i,
  output st_entry_t   head_o,
  output logic [CW-1:0] count_o,
  output logic        match_o
);

  st_entry_t         mem_q [DEPTH];
  st_entry_t         mem_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  // Next-state for storage, pointers and count; pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop_i && (count_q != CW'(0));
    do_push  = push_i && (count_q != CW'(DEPTH));
    if (do_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (do_push) begin
      mem_d[wr_ptr_q]   = push_entry_i;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Any valid entry holding the probed word address.
  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      match_o = match_o | (valid_q[i] && (mem_q[i].waddr == match_waddr_i));
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/store_buf.sv
// MEM-stage store path: decodes sw/sh/sb, checks alignment, queues stores in
// a small write buffer and drains it to data memory over a req/ack handshake.
module store_buf
  import store_buf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] InstrM,
  input  logic [31:0] AddrM,
  input  logic [31:0] WDataM,
  input  logic        MemAdv,
  output logic        StallSt,
  output logic        AdES,
  output logic        DmReq,
  output logic [29:0] DmAddr,
  output logic [3:0]  DmBE,
  output logic [31:0] DmWData,
  input  logic        DmAck,
  output logic        Empty
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [5:0]    op;
  logic [1:0]    lo;
  logic          is_store, is_load, aligned_st;
  logic          full, match, enq, pop;
  logic [CW-1:0] count_q, count_nxt;
  lane_t         lane;
  st_entry_t     push_entry, head;
  drain_state_e  state_q, state_d;
  logic          instr_unused;

  assign op           = InstrM[31:26];
  assign lo           = AddrM[1:0];
  assign instr_unused = ^InstrM[25:0];
  assign is_store     = is_store_op(op);
  assign is_load      = is_load_op(op);
  assign lane         = lane_encode(op, lo, WDataM);

  assign AdES = ((op == OP_SW) && (lo != 2'b00)) ||
                ((op == OP_SH) && lo[0]);
  assign aligned_st = is_store && !AdES;

  // Both stall terms look only at registered state, never at DmAck.
  assign full    = (count_q == CW'(DEPTH));
  assign StallSt = (aligned_st && full) || (is_load && match);
  assign enq     = aligned_st && MemAdv && !StallSt;
  assign pop     = (state_q == DR_REQ) && DmAck;

  assign push_entry = '{waddr: AddrM[31:2], be: lane.be, data: lane.data};

  st_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_i        (enq),
    .push_entry_i  (push_entry),
    .pop_i         (pop),
    .match_waddr_i (AddrM[31:2]),
    .head_o        (head),
    .count_o       (count_q),
    .match_o       (match)
  );

  assign count_nxt = count_q + CW'(enq) - CW'(pop);

  // Drain FSM next state: request whenever the buffer will hold an entry,
  // which gives one-cycle enqueue-to-request latency from empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DR_IDLE: begin
        if (count_nxt != CW'(0)) begin
          state_d = DR_REQ;
        end else begin
          state_d = DR_IDLE;
        end
      end
      DR_REQ: begin
        if (count_nxt == CW'(0)) begin
          state_d = DR_IDLE;
        end else begin
          state_d = DR_REQ;
        end
      end
      default: state_d = DR_IDLE;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign DmReq   = (state_q == DR_REQ);
  assign DmAddr  = head.waddr;
  assign DmBE    = head.be;
  assign DmWData = head.data;
  assign Empty   = (count_q == CW'(0));

endmodule

// File: doc/store_buf.md
# store_buf

Store-side companion to the load data extractor in the MEM/WB path of the 5-stage MIPS pipeline. Decodes `sw`/`sh`/`sb` in the MEM stage and produces byte-enables and lane-replicated write data. Queues each store in a small write buffer that drains to data memory over a req/ack handshake. Raises a pipeline stall when the buffer is full, and when a load targets a word still pending in the buffer. Flags misaligned stores.

## Interface
- `DEPTH`, 2: write-buffer entries; power of two, ≥2.
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `InstrM`  in  32  MEM-stage instruction; opcode in [31:26].
- `AddrM`  in  32  ALU-computed byte address.
- `WDataM`  in  32  forwarded rt value.
- `MemAdv`  in  1  MEM stage advances this cycle if this block does not stall; excludes `StallSt`.
- `StallSt`  out  1  freeze IF..MEM this cycle.
- `AdES`  out  1  misaligned-store exception; combinational.
- `DmReq`  out  1  memory write request.
- `DmAddr`  out  30  word address [31:2].
- `DmBE`  out  4  byte enables; bit i = byte [8i+7:8i].
- `DmWData`  out  32  write data.
- `DmAck`  in  1  memory accepted the current request.
- `Empty`  out  1  buffer empty; used by the hazard unit before `syscall`/`eret`.

## Operation
- Opcodes: `sw`=101011, `sh`=101001, `sb`=101000; loads are `lw`/`lh`/`lhu`/`lb`/`lbu` (100011/100001/100101/100000/100100).
- Lane encoding, with `lo`=AddrM[1:0]:
  - `sw`: BE=1111, data=WDataM.
  - `sh`: BE=0011 (`lo`=00) or 1100 (`lo`=10), data={2{WDataM[15:0]}}.
  - `sb`: BE=0001<<`lo`, data={4{WDataM[7:0]}}.
- Alignment:
  - `AdES`=1 for `sw` with `lo`≠00, or `sh` with `lo`[0]=1.
  - A misaligned store is never enqueued and never stalls.
- `StallSt` = (aligned store ∧ count==DEPTH) ∨ (load ∧ a valid entry has word address == AddrM[31:2]).
  - Both terms compare pre-pop state, so a same-cycle pop does not cancel a stall.
- Enqueue = aligned store ∧ MemAdv ∧ ¬StallSt. Writes {AddrM[31:2], BE, data} at the tail.
- No store-to-load forwarding. A load that matches a pending word waits until that entry drains.
- Drain FSM:
  - IDLE: go to REQ when count>0.
  - REQ: `DmReq`=1 with the head entry. On `DmAck`, pop the head; go to IDLE if count becomes 0, else stay in REQ and present the next head in the following cycle.
  - Head outputs hold stable while `DmReq`=1 and `DmAck`=0.
- Simultaneous enqueue and pop: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.

## Timing
- Reset, asynchronous: count=0, pointers=0, state=IDLE, `DmReq`=0, `Empty`=1. `DmAddr`/`DmBE`/`DmWData`=0.
- `StallSt` and `AdES` are combinational from the MEM inputs and registered state. No comb path exists from `DmAck` to `StallSt`.
- Enqueue-to-`DmReq` latency from an empty buffer is 1 cycle: enqueue at edge N, then `DmReq`=1 in cycle N+1.
- Throughput is one store per cycle while `DmAck` is held high.
- Reset mid-transaction drops the buffered stores. `DmReq` deasserts immediately (asynchronously).
- `DmAck` is ignored when `DmReq`=0.

## Structure
- Shared MIPS package holds the opcode constants (shared with the load extractor and controller) and the lane/BE encoding function.
- One sub-module, `st_fifo`: a parameterised DEPTH-entry FIFO with count, valid bits, and a per-entry word-address match port.
- The top level contains the decode, the alignment check, the stall logic, and the drain FSM.

## Test plan
- `sb` $t=0x000000A5 to 0x1003, MemAdv=1, DmAck=1 → next cycle: DmReq=1, DmAddr=0x400, DmBE=1000, DmWData=0xA5A5A5A5.
- `sh` 0x1234 to 0x2002, then `sw` 0xDEADBEEF to 0x2004, with DmAck=0 → after the 2 enqueues count=2. A third `sw` gives StallSt=1 until the first DmAck, then enqueues 1 cycle later. Drain order is BE=1100 / 0x12341234, then BE=1111 / 0xDEADBEEF.
- `sw` to 0x3000 pending, then `lw` from 0x3000 → StallSt=1 until the pop edge. `lw` from 0x3004 → StallSt=0.
- `sh` to 0x0001 → AdES=1, StallSt=0, no enqueue, Empty stays 1. `sw` to 0x0002 → AdES=1.
- Full buffer with DmAck=1 and a new store in the same cycle → StallSt=1 that cycle. The store enqueues the next cycle, and count never exceeds DEPTH.
- rst_n low while DmReq=1 and count=2 → DmReq=0 and Empty=1 immediately. After release, no stale request is issued.
